jump_sequencer: RTL and testbench

JUMP_SEQUENCER -- requirements
Module: jump_sequencer

---
 rtl/jump_pkg.sv | 22 ++
 rtl/jump_label_table.sv | 28 ++
 rtl/jump_sequencer.sv | 80 ++++++++
 tb/tb_jump_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/jump_pkg.sv
// Shared types and constants for the jump sequencer: FSM states, widths and
// the power-on contents of the label table.
package jump_pkg;

  localparam int PC_W  = 16;
  localparam int LBL_W = 4;
  localparam int LBL_N = 1 << LBL_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] LBL_DEFAULT [LBL_N] = '{
    16'd152, 16'd22,  16'd102, 16'd152,
    16'd196, 16'd212, 16'd8,   16'd39,
    16'd18,  16'd46,  16'd83,  16'd60,
    16'd0,   16'd0,   16'd0,   16'd0
  };

endpackage

// File: rtl/jump_label_table.sv
// 16-entry branch-label store: one synchronous write port, one asynchronous
// read port, defaults reloaded on reset.
module jump_label_table
  import jump_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [LBL_W-1:0] waddr,
  input  logic [PC_W-1:0]  wdata,
  input  logic [LBL_W-1:0] raddr,
  output logic [PC_W-1:0]  rdata
);

  logic [PC_W-1:0] mem [LBL_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LBL_N; i++) mem[i] <= LBL_DEFAULT[i];
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read sees the pre-edge contents, so a same-cycle write is not bypassed.
  assign rdata = mem[raddr];

endmodule

// File: rtl/jump_sequencer.sv
// Fetch-address sequencer: free-running PC with stall, taken-branch redirect
// (absolute or via label table), halt, restart and a taken-branch counter.
module jump_sequencer
  import jump_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  input  logic             halt_in,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic             br_mode,
  input  logic [PC_W-1:0]  br_target,
  input  logic [LBL_W-1:0] br_label,
  input  logic             lbl_we,
  input  logic [LBL_W-1:0] lbl_waddr,
  input  logic [PC_W-1:0]  lbl_wdata,
  output logic [PC_W-1:0]  pc,
  output logic             pc_valid,
  output logic             flush,
  output logic             done,
  output logic [PC_W-1:0]  taken_cnt,
  output state_t           fsm_state
);

  state_t          state;
  logic [PC_W-1:0] lbl_target;
  logic [PC_W-1:0] br_dest;
  logic            take;

  jump_label_table u_label_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (lbl_we),
    .waddr (lbl_waddr),
    .wdata (lbl_wdata),
    .raddr (br_label),
    .rdata (lbl_target)
  );

  // A restart outranks a branch, so a branch coinciding with start is not taken.
  assign take      = (state == S_RUN) && br_valid && br_taken && !start;
  assign br_dest   = br_mode ? br_target : lbl_target;
  assign flush     = take;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      pc_valid  <= 1'b0;
      done      <= 1'b0;
      taken_cnt <= '0;
    end else if (start) begin
      state     <= S_RUN;
      pc        <= '0;
      pc_valid  <= 1'b1;
      done      <= 1'b0;
      taken_cnt <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (take) begin
            pc        <= br_dest;
            taken_cnt <= taken_cnt + 1'b1;
          end else if (halt_in) begin
            state    <= S_HALT;
            pc_valid <= 1'b0;
            done     <= 1'b1;
          end else if (!stall) begin
            pc <= pc + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jump_sequencer.sv
// Self-checking bench for jump_sequencer: directed vector table, label-table
// default sweep, mid-run reset, then randomized traffic against a behavioural model.
module tb_jump_sequencer;
  import jump_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start, stall, halt_in, br_valid, br_taken, br_mode, lbl_we;
  logic [15:0] br_target, lbl_wdata;
  logic [3:0]  br_label, lbl_waddr;
  logic [15:0] pc, taken_cnt;
  logic        pc_valid, flush, done;
  state_t      fsm_state;

  jump_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt_in(halt_in),
    .br_valid(br_valid), .br_taken(br_taken), .br_mode(br_mode),
    .br_target(br_target), .br_label(br_label), .lbl_we(lbl_we),
    .lbl_waddr(lbl_waddr), .lbl_wdata(lbl_wdata), .pc(pc), .pc_valid(pc_valid),
    .flush(flush), .done(done), .taken_cnt(taken_cnt), .fsm_state(fsm_state)
  );

  typedef struct packed {
    logic start, stall, halt, bv, bt, bm;
    logic [15:0] tgt;
    logic [3:0]  lbl;
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
  } in_t;

  typedef struct {
    in_t         in;
    logic [15:0] pc;
    logic        v, f, d;
    logic [15:0] cnt;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural reference model ----------------
  bit          m_running, m_halted;
  int unsigned m_pc, m_cnt;
  int unsigned m_lbl [16];
  int unsigned defaults [16] = '{152, 22, 102, 152, 196, 212, 8, 39, 18, 46, 83, 60, 0, 0, 0, 0};

  function automatic void model_reset();
    m_running = 0; m_halted = 0; m_pc = 0; m_cnt = 0;
    foreach (m_lbl[k]) m_lbl[k] = defaults[k];
  endfunction

  function automatic bit model_take(input in_t i);
    return m_running && i.bv && i.bt && !i.start;
  endfunction

  function automatic void model_step(input in_t i);
    int unsigned dest;
    dest = i.bm ? int'(i.tgt) : m_lbl[i.lbl];
    if (i.start) begin
      m_running = 1; m_halted = 0; m_pc = 0; m_cnt = 0;
    end else if (m_running) begin
      if (i.bv && i.bt) begin
        m_pc = dest; m_cnt = (m_cnt + 1) % 65536;
      end else if (i.halt) begin
        m_running = 0; m_halted = 1;
      end else if (!i.stall) begin
        m_pc = (m_pc + 1) % 65536;
      end
    end
    if (i.we) m_lbl[i.wa] = i.wd;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input in_t i);
    start = i.start; stall = i.stall; halt_in = i.halt;
    br_valid = i.bv; br_taken = i.bt; br_mode = i.bm;
    br_target = i.tgt; br_label = i.lbl;
    lbl_we = i.we; lbl_waddr = i.wa; lbl_wdata = i.wd;
  endtask

  // One cycle: drive on falling edge, check mid-low-phase, advance model at rising edge.
  task automatic cycle(input in_t i, input bit use_tab, input vec_t e, input string tag);
    @(negedge clk);
    drive(i);
    #1;
    if (use_tab) begin
      chk({tag, " pc"},       pc,        e.pc);
      chk({tag, " pc_valid"}, pc_valid,  e.v);
      chk({tag, " flush"},    flush,     e.f);
      chk({tag, " done"},     done,      e.d);
      chk({tag, " taken"},    taken_cnt, e.cnt);
    end else begin
      chk({tag, " pc"},       pc,        m_pc[15:0]);
      chk({tag, " pc_valid"}, pc_valid,  m_running);
      chk({tag, " flush"},    flush,     model_take(i));
      chk({tag, " done"},     done,      m_halted);
      chk({tag, " taken"},    taken_cnt, m_cnt[15:0]);
    end
    @(posedge clk);
    model_step(i);
  endtask

  function automatic vec_t row(input bit s, st, h, bv, bt, bm, input logic [15:0] tgt,
                               input logic [3:0] lbl, input logic [15:0] epc,
                               input bit ev, ef, ed, input logic [15:0] ecnt);
    vec_t r;
    r.in = '0;
    r.in.start = s; r.in.stall = st; r.in.halt = h;
    r.in.bv = bv; r.in.bt = bt; r.in.bm = bm; r.in.tgt = tgt; r.in.lbl = lbl;
    r.pc = epc; r.v = ev; r.f = ef; r.d = ed; r.cnt = ecnt;
    return r;
  endfunction

  vec_t tab [22];
  vec_t none_v;
  in_t  ri;

  initial begin
    // Directed table: expected outputs are those visible while the row's inputs are applied.
    //            s  st h  bv bt bm tgt       lbl  pc        v  f  d  cnt
    tab[0]  = row(0, 0, 0, 0, 0, 0, 16'd0,    4'd0, 16'd0,    0, 0, 0, 16'd0);
    tab[1]  = row(1, 0, 0, 0, 0, 0, 16'd0,    4'd0, 16'd0,    0, 0, 0, 16'd0);
    tab[2]  = row(0, 0, 0, 0, 0, 0, 16'd0,    4'd0, 16'd0,    1, 0, 0, 16'd0);
    tab[3]  = row(0, 0, 0, 0, 0, 0, 16'd0,    4'd0, 16'd1,    1, 0, 0, 16'd0);
    tab[4]  = row(0, 0, 0, 0, 0, 0, 16'd0,    4'd0, 16'd2,    1, 0, 0, 16'd0);
    tab[5]  = row(0, 0, 0, 1, 1, 0, 16'd0,    4'd7, 16'd3,    1, 1, 0, 16'd0);
    tab[6]  = row(0, 0, 0, 1, 1, 0, 16'd0,    4'd7, 16'd39,   1, 1, 0, 16'd1);
    tab[7]  = row(0, 0, 0, 1, 1, 0, 16'd0,    4'd7, 16'd39,   1, 1, 0, 16'd2);
    tab[8]  = row(0, 1, 0, 1, 1, 1, 16'd500,  4'd0, 16'd300,  1, 1, 0, 16'd3);
    tab[9]  = row(0, 1, 0, 0, 0, 0, 16'd0,    4'd0, 16'd500,  1, 0, 0, 16'd4);
    tab[10] = row(0, 1, 0, 0, 0, 0, 16'd0,    4'd0, 16'd500,  1, 0, 0, 16'd4);
    tab[11] = row(0, 1, 0, 0, 0, 0, 16'd0,    4'd0, 16'd500,  1, 0, 0, 16'd4);
    tab[12] = row(0, 0, 0, 0, 0, 0, 16'd0,    4'd0, 16'd500,  1, 0, 0, 16'd4);
    tab[13] = row(0, 0, 1, 1, 1, 1, 16'd1000, 4'd0, 16'd501,  1, 1, 0, 16'd4);
    tab[14] = row(0, 0, 1, 0, 0, 0, 16'd0,    4'd0, 16'd1000, 1, 0, 0, 16'd5);
    tab[15] = row(0, 1, 1, 1, 1, 1, 16'd7,    4'd0, 16'd1000, 0, 0, 1, 16'd5);
    tab[16] = row(1, 0, 0, 0, 0, 0, 16'd0,    4'd0, 16'd1000, 0, 0, 1, 16'd5);
    tab[17] = row(0, 0, 0, 0, 0, 0, 16'd0,    4'd0, 16'd0,    1, 0, 0, 16'd0);
    tab[18] = row(0, 0, 0, 1, 1, 1, 16'hFFFF, 4'd0, 16'd1,    1, 1, 0, 16'd0);
    tab[19] = row(0, 0, 0, 0, 0, 0, 16'd0,    4'd0, 16'hFFFF, 1, 0, 0, 16'd1);
    tab[20] = row(0, 0, 0, 0, 0, 0, 16'd0,    4'd0, 16'd0,    1, 0, 0, 16'd1);
    tab[21] = row(0, 0, 0, 0, 0, 0, 16'd0,    4'd0, 16'd1,    1, 0, 0, 16'd1);
    // Same-cycle write to label 7 must not affect this cycle's lookup.
    tab[6].in.we = 1'b1; tab[6].in.wa = 4'd7; tab[6].in.wd = 16'd300;
    none_v = row(0, 0, 0, 0, 0, 0, 16'd0, 4'd0, 16'd0, 0, 0, 0, 16'd0);

    drive('0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 22; n++) cycle(tab[n].in, 1'b1, tab[n], $sformatf("vec%0d", n));

    // Reset asserted mid-RUN takes effect without waiting for a clock edge.
    @(negedge clk);
    ri = '0; ri.bv = 1; ri.bt = 1; ri.bm = 1; ri.tgt = 16'd77;
    drive(ri);
    rst_n = 1'b0;
    #1;
    chk("async_rst pc", pc, 16'd0);
    chk("async_rst pc_valid", pc_valid, 1'b0);
    chk("async_rst flush", flush, 1'b0);
    chk("async_rst done", done, 1'b0);
    chk("async_rst taken", taken_cnt, 16'd0);
    model_reset();
    @(negedge clk);
    drive('0);
    rst_n = 1'b1;
    // Without a start pulse the block must stay idle.
    repeat (3) cycle('0, 1'b0, none_v, "post_rst");

    // Sweep every label through its reset default.
    ri = '0; ri.start = 1;
    cycle(ri, 1'b0, none_v, "sweep_start");
    for (int l = 0; l < 16; l++) begin
      ri = '0; ri.bv = 1; ri.bt = 1; ri.lbl = l[3:0];
      cycle(ri, 1'b0, none_v, $sformatf("sweep_lbl%0d", l));
      cycle('0, 1'b0, none_v, $sformatf("sweep_dst%0d", l));
    end

    // Randomized traffic checked against the model.
    for (int n = 0; n < 600; n++) begin
      ri       = '0;
      ri.start = (n == 0) || ($urandom_range(0, 39) == 0);
      ri.stall = ($urandom_range(0, 3) == 0);
      ri.halt  = ($urandom_range(0, 29) == 0);
      ri.bv    = ($urandom_range(0, 3) == 0);
      ri.bt    = $urandom_range(0, 1);
      ri.bm    = $urandom_range(0, 1);
      ri.tgt   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      ri.lbl   = 4'($urandom_range(0, 15));
      ri.we    = ($urandom_range(0, 4) == 0);
      ri.wa    = 4'($urandom_range(0, 15));
      ri.wd    = 16'($urandom);
      cycle(ri, 1'b0, none_v, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
